// File: rtl/alu_pkg.sv
// Shared ALU types: operation codes, EX-stage state encoding, helpers.
// Imported by the ALU controller and the execute unit.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SRA = 4'b0111,
        ALU_EQ  = 4'b1000,
        ALU_SLT = 4'b1100
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter with down-counter.
// Only used when ALU_BARREL_SHIFT_EN is undefined.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  right_i,
    input  logic                  arith_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [SHAMT_W-1:0]    shamt_i,
    output logic [DATA_WIDTH-1:0] step_o,
    output logic                  busy_o,
    output logic                  last_o
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [SHAMT_W-1:0]    cnt_q, cnt_d;
    logic                  right_q, right_d;
    logic                  arith_q, arith_d;

    assign busy_o = (cnt_q != '0);
    assign last_o = (cnt_q == CNT_ONE);

    // step_o is the register value after one more shift
    assign step_o = right_q
        ? {arith_q & sh_q[DATA_WIDTH-1], sh_q[DATA_WIDTH-1:1]}
        : {sh_q[DATA_WIDTH-2:0], 1'b0};

    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        right_d = right_q;
        arith_d = arith_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            sh_d    = data_i;
            cnt_d   = shamt_i;
            right_d = right_i;
            arith_d = arith_i;
        end else if (busy_o) begin
            sh_d  = step_o;
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            right_q <= right_d;
            arith_q <= arith_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake and iterative shifts.
// Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_OP_W-1:0]   operation,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  illegal_op
);

    alu_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  legal;
    logic                  start_shift;
    logic                  lt;
    logic [SHAMT_W-1:0]    shamt;

    assign shamt = op_b[SHAMT_W-1:0];
    assign lt    = $signed(op_a) < $signed(op_b);

`ifdef ALU_BARREL_SHIFT_EN
    assign start_shift = 1'b0;
`else
    logic                  shift_load;
    logic [DATA_WIDTH-1:0] shift_step;
    logic                  shift_busy;
    logic                  shift_last;

    assign start_shift = is_shift(operation) && (shamt != '0);

    alu_shift_iter #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHAMT_W    (SHAMT_W)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush),
        .load_i  (shift_load),
        .right_i (operation != ALU_SLL),
        .arith_i (operation == ALU_SRA),
        .data_i  (op_a),
        .shamt_i (shamt),
        .step_o  (shift_step),
        .busy_o  (shift_busy),
        .last_o  (shift_last)
    );
`endif

    always_comb begin
        alu_res = '0;
        legal   = 1'b1;
        case (operation)
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_ADD: alu_res = op_a + op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_EQ:  alu_res = {{(DATA_WIDTH-1){1'b0}}, op_a == op_b};
            ALU_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, lt};
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL: alu_res = op_a << shamt;
            ALU_SRL: alu_res = op_a >> shamt;
            ALU_SRA: alu_res = $unsigned($signed(op_a) >>> shamt);
`else
            // only reached with shamt == 0; longer shifts iterate
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
`endif
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifndef ALU_BARREL_SHIFT_EN
        shift_load = 1'b0;
`endif
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (start_shift) begin
`ifndef ALU_BARREL_SHIFT_EN
                            shift_load = 1'b1;
`endif
                            state_d = SHIFT;
                        end else begin
                            result_d  = alu_res;
                            zero_d    = (alu_res == '0);
                            illegal_d = !legal;
                            state_d   = DONE;
                        end
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    if (shift_busy && shift_last) begin
                        result_d  = shift_step;
                        zero_d    = (shift_step == '0);
                        illegal_d = 1'b0;
                        state_d   = DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign result     = result_q;
    assign zero       = zero_q;
    assign illegal_op = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit Operation code from the ALU controller, together with two operands from the ID/EX register. Most ops complete in one cycle; shifts run iteratively at one bit per cycle. The block uses a valid/ready handshake on both sides so the pipeline controller can stall EX while a shift is in progress. It produces the result, a zero flag for the branch logic, and an illegal-op flag.

Parameters:
- DATA_WIDTH, 32, operand and result width (power of two, minimum 8).
- SHAMT_W, $clog2(DATA_WIDTH), width of the shift-amount field taken from op_b LSBs.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous abort of the current op (branch mispredict / trap).
- in_valid, input, 1, operands and operation are valid.
- in_ready, output, 1, unit can accept an op.
- operation, input, 4, ALU op code (alu_pkg::alu_op_t).
- op_a, input, DATA_WIDTH, operand A (rs1 / PC).
- op_b, input, DATA_WIDTH, operand B (rs2 / immediate).
- out_valid, output, 1, result registers valid.
- out_ready, input, 1, downstream (EX/MEM) accepts the result.
- result, output, DATA_WIDTH, registered result.
- zero, output, 1, registered (result == 0).
- illegal_op, output, 1, registered; operation code is not in the table.

Behaviour:
- One clock; reset is asynchronous and active-low. All state is cleared on rst_n=0.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, illegal_op=0.
- Op codes:
  - AND=0000, OR=0001, ADD=0010, XOR=0011, SLL=0100, SRL=0101, SUB=0110, SRA=0111, EQ=1000, SLT=1100.
  - All other codes are illegal.
- EQ returns 1 when op_a==op_b, else 0. SLT is a signed compare and returns 1/0. ADD and SUB wrap modulo 2^DATA_WIDTH.
- Shift amount is op_b[SHAMT_W-1:0]; upper bits of op_b are ignored. SRA replicates the sign bit.
- State machine: IDLE -> SHIFT -> DONE.
  - IDLE: in_ready=1. An op is accepted when in_valid && in_ready.
  - Non-shift op or illegal op: the result is computed combinationally and registered; next state is DONE.
  - Illegal op: result=0, illegal_op=1.
  - Shift op with shamt=0: result=op_a; next state is DONE.
  - Shift op with shamt>0: load the shift register with op_a and the counter with shamt; next state is SHIFT.
  - SHIFT: in_ready=0. Each cycle the register shifts by 1 and the counter decrements. When the counter reaches 1, the last shift is performed and the next state is DONE.
  - DONE: out_valid=1 and in_ready=0. result, zero and illegal_op are held stable until out_ready=1, then the next state is IDLE.
- Latency from the accept edge to out_valid high:
  - non-shift ops: 1 cycle.
  - shift by N (N>0): N+1 cycles.
- Throughput: at most one op every 2 cycles (no accept while in DONE).
- zero is updated together with result. When illegal_op=1, zero=1.
- flush has priority over everything except reset. flush=1 in any state forces state=IDLE, out_valid=0 and clears the counter. result, zero and illegal_op hold their values.
  - An op offered together with flush is not accepted: in_ready is still 1, but the transfer is discarded.
- Unknown state encoding recovers to IDLE.
- Asserting rst_n low mid-shift aborts immediately; outputs take their reset values.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter and complete in 1 cycle like the other ops. The SHIFT state and counter are not generated.
- Undefined: iterative 1-bit/cycle shifter as described above.
- Result values are identical in both builds; only latency differs.

Decomposition:
- alu_pkg holds:
  - alu_op_t, a 4-bit enum with the codes above;
  - alu_state_t, the enum IDLE/SHIFT/DONE;
  - localparam ALU_OP_W=4.
- The ALU controller imports the same package.
- One sub-module, alu_shift_iter: shift register, down-counter, direction and arithmetic select, with load, busy and last outputs. It is excluded when ALU_BARREL_SHIFT_EN is defined.

Test Plan:
1. Reset release, then ADD 0x7FFFFFFF + 0x00000001 -> out_valid 1 cycle after accept, result=0x80000000, zero=0. SUB 5-5 -> result=0, zero=1.
2. SRA op_a=0x80000000, op_b=0x00000024 (shamt 4) -> in_ready low for 4 cycles, out_valid on cycle 5, result=0xF8000000. Repeat with SLL shamt 0 -> 1-cycle result=op_a.
3. Backpressure: SLT -3 vs 2 with out_ready=0 for 6 cycles -> result=1 held stable, in_ready=0 throughout. One cycle after out_ready=1, unit is back in IDLE.
4. Illegal code 1111 -> result=0, illegal_op=1, zero=1. The next legal op (OR 0xF0|0x0F=0xFF) clears illegal_op.
5. flush on the third cycle of SRL 0xFFFFFFFF by 31 -> out_valid never asserts, in_ready=1 next cycle. A new EQ 7==7 then returns result=1.
6. rst_n pulsed low mid-shift (asynchronous, between clock edges) -> out_valid=0 and result=0 immediately. Rebuild with ALU_BARREL_SHIFT_EN and rerun scenario 2 -> 1-cycle latency, same result.
